// File: rtl/skintone_pkg.sv
// Skin-tone chroma model constants shared by the mean chroma pipeline.
// Slopes are unsigned Q0.9 fractions; centres are integer chroma levels.
package skintone_pkg;

    localparam int K_L   = 125;
    localparam int K_H   = 188;
    localparam int Y_MIN = 16;
    localparam int Y_MAX = 235;
    localparam int CB_C  = 108;
    localparam int CR_C  = 154;
    localparam int CB_SL = 47;
    localparam int CB_SH = 109;
    localparam int CR_SL = 47;
    localparam int CR_SH = 240;

    typedef enum logic [1:0] {
        LOW,
        MID,
        HIGH
    } region_t;

endpackage

// File: rtl/mean_chroma_pipe_if.sv
// Stream bundle for mean_chroma_pipe: luma/tag in, chroma centres/tag out.
// The slave modport is the pipeline side; master is the source/sink side.
interface mean_chroma_pipe_if #(
    parameter int Y_W    = 8,
    parameter int FRAC_W = 9,
    parameter int TAG_W  = 16
) ();

    localparam int OUT_W = 9 + FRAC_W;

    logic [Y_W-1:0]   y_in;
    logic [TAG_W-1:0] tag_in;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] mean_cb;
    logic [OUT_W-1:0] mean_cr;
    logic [TAG_W-1:0] tag_out;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output y_in, tag_in, in_valid, out_ready,
        input  in_ready, mean_cb, mean_cr, tag_out, out_valid
    );

    modport slave (
        input  y_in, tag_in, in_valid, out_ready,
        output in_ready, mean_cb, mean_cr, tag_out, out_valid
    );

endinterface

// File: rtl/mean_chroma_lane.sv
// One chroma channel: S2 multiplies delta by the region slope, S3 offsets
// the centre up or down by that product. Both stages hold while en is low.
module mean_chroma_lane
    import skintone_pkg::*;
#(
    parameter int Y_W        = 8,
    parameter int FRAC_W     = 9,
    parameter int CENTRE     = 0,
    parameter int LOW_SLOPE  = 0,
    parameter int HIGH_SLOPE = 0,
    parameter bit LOW_SUB    = 1'b0,
    parameter bit HIGH_SUB   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  region_t             region,
    input  logic [Y_W-1:0]      delta,
    output logic [9+FRAC_W-1:0] mean
);

    localparam int OUT_W  = 9 + FRAC_W;
    localparam int PROD_W = Y_W + FRAC_W;
    localparam int SUM_W  = ((OUT_W > PROD_W) ? OUT_W : PROD_W) + 1;

    localparam logic [PROD_W-1:0] LOW_SLOPE_V  = PROD_W'(LOW_SLOPE);
    localparam logic [PROD_W-1:0] HIGH_SLOPE_V = PROD_W'(HIGH_SLOPE);
    localparam logic [SUM_W-1:0]  CENTRE_V     = SUM_W'(CENTRE);

    logic [PROD_W-1:0]      prod_q;
    logic                   sub_q;
    logic [SUM_W-1:0]       sum;
    logic [SUM_W-OUT_W-1:0] sum_unused_msb;

    // MID carries a zero product, so the output lands exactly on the centre.
    always_ff @(posedge clk) begin
        if (en) begin
            unique case (region)
                LOW: begin
                    prod_q <= PROD_W'(delta) * LOW_SLOPE_V;
                    sub_q  <= LOW_SUB;
                end
                HIGH: begin
                    prod_q <= PROD_W'(delta) * HIGH_SLOPE_V;
                    sub_q  <= HIGH_SUB;
                end
                default: begin
                    prod_q <= '0;
                    sub_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        sum = sub_q ? (CENTRE_V - SUM_W'(prod_q)) : (CENTRE_V + SUM_W'(prod_q));
    end

    assign sum_unused_msb = sum[SUM_W-1:OUT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            mean <= '0;
        end else if (en) begin
            mean <= sum[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/mean_chroma_pipe.sv
// Three-stage pipeline mapping luma to skin-tone Cb/Cr cluster centres.
// Define MEAN_CHROMA_CLAMP_EN to clamp luma to [Y_MIN, Y_MAX] before classification.
module mean_chroma_pipe
    import skintone_pkg::*;
#(
    parameter int Y_W    = 8,
    parameter int FRAC_W = 9,
    parameter int TAG_W  = 16
) (
    input logic               clk,
    input logic               rst,
    mean_chroma_pipe_if.slave bus
);

    logic             advance;
    logic [Y_W-1:0]   y_eff;
    region_t          region_c;
    logic [Y_W-1:0]   delta_c;

    logic             s1_valid;
    logic             s2_valid;
    logic             s3_valid;
    region_t          s1_region;
    logic [Y_W-1:0]   s1_delta;
    logic [TAG_W-1:0] s1_tag;
    logic [TAG_W-1:0] s2_tag;
    logic [TAG_W-1:0] s3_tag;

    // One global enable: the whole pipe freezes while the output is held.
    assign advance       = !s3_valid || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = s3_valid;
    assign bus.tag_out   = s3_tag;

`ifdef MEAN_CHROMA_CLAMP_EN
    always_comb begin
        y_eff = bus.y_in;
        if (bus.y_in < Y_W'(Y_MIN)) begin
            y_eff = Y_W'(Y_MIN);
        end else if (bus.y_in > Y_W'(Y_MAX)) begin
            y_eff = Y_W'(Y_MAX);
        end
    end
`else
    assign y_eff = bus.y_in;
`endif

    always_comb begin
        region_c = MID;
        delta_c  = '0;
        if (y_eff < Y_W'(K_L)) begin
            region_c = LOW;
            delta_c  = Y_W'(K_L) - y_eff;
        end else if (y_eff > Y_W'(K_H)) begin
            region_c = HIGH;
            delta_c  = y_eff - Y_W'(K_H);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= bus.in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_region <= region_c;
            s1_delta  <= delta_c;
            s1_tag    <= bus.tag_in;
            s2_tag    <= s1_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_tag <= '0;
        end else if (advance) begin
            s3_tag <= s2_tag;
        end
    end

    mean_chroma_lane #(
        .Y_W        (Y_W),
        .FRAC_W     (FRAC_W),
        .CENTRE     (CB_C * (2 ** FRAC_W)),
        .LOW_SLOPE  (CB_SL),
        .HIGH_SLOPE (CB_SH),
        .LOW_SUB    (1'b0),
        .HIGH_SUB   (1'b0)
    ) u_cb_lane (
        .clk    (clk),
        .rst    (rst),
        .en     (advance),
        .region (s1_region),
        .delta  (s1_delta),
        .mean   (bus.mean_cb)
    );

    // Cr falls below its centre for dark skin and rises above it for bright skin.
    mean_chroma_lane #(
        .Y_W        (Y_W),
        .FRAC_W     (FRAC_W),
        .CENTRE     (CR_C * (2 ** FRAC_W)),
        .LOW_SLOPE  (CR_SL),
        .HIGH_SLOPE (CR_SH),
        .LOW_SUB    (1'b1),
        .HIGH_SUB   (1'b0)
    ) u_cr_lane (
        .clk    (clk),
        .rst    (rst),
        .en     (advance),
        .region (s1_region),
        .delta  (s1_delta),
        .mean   (bus.mean_cr)
    );

endmodule

// File: tb/tb_mean_chroma_pipe.sv
// Directed bench for mean_chroma_pipe: reset, per-region vectors, stalled
// stream and mid-stream reset, against hand-computed Q9.9 chroma centres.
module tb_mean_chroma_pipe;

    localparam int Y_W    = 8;
    localparam int FRAC_W = 9;
    localparam int TAG_W  = 16;
    localparam int NV     = 10;
    localparam int NS     = 20;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   vy  [NV];
    int   vcb [NV];
    int   vcr [NV];

    always #5 clk = ~clk;

    mean_chroma_pipe_if #(.Y_W(Y_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) bus ();

    mean_chroma_pipe #(.Y_W(Y_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, observed, expected);
        end
    endtask

    // Pushes one sample into an empty pipe and expects it on the third edge.
    task automatic applyStimulus(input int y, input int tg, input int ecb,
                                 input int ecr, input string name);
        bus.y_in     = y[Y_W-1:0];
        bus.tag_in   = tg[TAG_W-1:0];
        bus.in_valid = 1'b1;
        #1;
        checkOutput({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput({name, "_early"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({name, "_cb"}, 32'(bus.mean_cb), ecb);
        checkOutput({name, "_cr"}, 32'(bus.mean_cr), ecr);
        checkOutput({name, "_tag"}, 32'(bus.tag_out), tg);
        @(posedge clk); #1;
        checkOutput({name, "_bubble"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit mv [3];
        bit adv_m;
        int tx;
        int rx;
        int k;

        vy[0] = 150; vcb[0] = 55296; vcr[0] = 78848;
        vy[1] = 100; vcb[1] = 56471; vcr[1] = 77673;
        vy[2] = 200; vcb[2] = 56604; vcr[2] = 81728;
        vy[3] = 125; vcb[3] = 55296; vcr[3] = 78848;
        vy[4] = 188; vcb[4] = 55296; vcr[4] = 78848;
        vy[5] = 124; vcb[5] = 55343; vcr[5] = 78801;
        vy[6] = 189; vcb[6] = 55405; vcr[6] = 79088;
        vy[7] = 50;  vcb[7] = 58821; vcr[7] = 75323;
`ifdef MEAN_CHROMA_CLAMP_EN
        vy[8] = 0;   vcb[8] = 60419; vcr[8] = 73725;
        vy[9] = 255; vcb[9] = 60419; vcr[9] = 90128;
`else
        vy[8] = 0;   vcb[8] = 61171; vcr[8] = 72973;
        vy[9] = 255; vcb[9] = 62599; vcr[9] = 94928;
`endif

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.y_in      = '0;
        bus.tag_in    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_cb", 32'(bus.mean_cb), 32'd0);
        checkOutput("rst_cr", 32'(bus.mean_cr), 32'd0);
        checkOutput("rst_tag", 32'(bus.tag_out), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vy[i], 16'h0100 + i, vcb[i], vcr[i], $sformatf("y%0d", vy[i]));
        end

        // Stream with a random sink; mv tracks which stages should hold samples.
        mv = '{1'b0, 1'b0, 1'b0};
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 400 && rx < NS; cyc++) begin
            bus.out_ready = ($urandom_range(0, 1) == 1);
            if (tx < NS) begin
                bus.in_valid = 1'b1;
                bus.y_in     = vy[tx % NV][Y_W-1:0];
                bus.tag_in   = TAG_W'(16'hA000 + tx);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            adv_m = !mv[2] || bus.out_ready;
            checkOutput("stream_in_ready", 32'(bus.in_ready), 32'(adv_m));
            checkOutput("stream_out_valid", 32'(bus.out_valid), 32'(mv[2]));
            if (mv[2] && bus.out_ready) begin
                k = rx % NV;
                checkOutput("stream_tag", 32'(bus.tag_out), 32'(16'hA000 + rx));
                checkOutput("stream_cb", 32'(bus.mean_cb), vcb[k]);
                checkOutput("stream_cr", 32'(bus.mean_cr), vcr[k]);
                rx++;
            end
            if (bus.in_valid && adv_m) tx++;
            if (adv_m) begin
                mv[2] = mv[1];
                mv[1] = mv[0];
                mv[0] = bus.in_valid;
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("stream_sent", 32'(tx), NS);
        checkOutput("stream_received", 32'(rx), NS);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.y_in     = vy[i + 1][Y_W-1:0];
            bus.tag_in   = TAG_W'(16'hB000 + i);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midrst_cb", 32'(bus.mean_cb), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("midrst_no_stale", 32'(bus.out_valid), 32'd0);
        end
        applyStimulus(150, 16'h0C0D, 55296, 78848, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mean_chroma_pipe.md
MEAN_CHROMA_PIPE -- requirements
Module: mean_chroma_pipe

Interface
REQ-001 Parameter Y_W, default 8, luma input width (unsigned).
REQ-002 Parameter FRAC_W, default 9, fractional bits of outputs; OUT_W = 9 + FRAC_W.
REQ-003 Parameter TAG_W, default 16, sideband passed through alongside each sample.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 y_in  input  Y_W  luma sample.
REQ-007 tag_in  input  TAG_W  sideband (e.g. pixel Cb/Cr, coordinates).
REQ-008 in_valid  input  1  y_in/tag_in valid.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 mean_cb  output  OUT_W  unsigned Q9.FRAC_W Cb cluster centre for y_in.
REQ-011 mean_cr  output  OUT_W  unsigned Q9.FRAC_W Cr cluster centre for y_in.
REQ-012 tag_out  output  TAG_W  tag_in of the same sample.
REQ-013 out_valid  output  1  outputs valid.
REQ-014 out_ready  input  1  downstream accepts outputs.

Function
REQ-015 Transfer in on in_valid && in_ready; out on out_valid && out_ready.
REQ-016 Three-stage pipeline (S1 region/delta, S2 multiply, S3 add/sub); latency exactly 3 cycles from input transfer to out_valid with no stall; one sample per cycle sustained.
REQ-017 Global stall: advance = !out_valid || out_ready; in_ready = advance; all stages hold when !advance; no sample dropped or duplicated.
REQ-018 Per-stage valid bit; bubbles propagate; out_valid driven by S3 valid.
REQ-019 Regions: LOW if y < K_L, HIGH if y > K_H, MID otherwise (K_L and K_H themselves are MID).
REQ-020 delta = K_L - y (LOW), y - K_H (HIGH), 0 (MID); unsigned, Y_W bits.
REQ-021 Cb = CB_C*2^FRAC_W + delta*CB_SL (LOW) or + delta*CB_SH (HIGH).
REQ-022 Cr = CR_C*2^FRAC_W - delta*CR_SL (LOW) or + delta*CR_SH (HIGH).
REQ-023 Slopes are unsigned Q0.FRAC_W; products full width (Y_W + FRAC_W bits); sums computed one bit wider, then truncated to OUT_W.
REQ-024 MID outputs are exactly the centre values, never zero.
REQ-025 tag travels in lockstep with its sample through all stages.
REQ-026 in_valid && !in_ready: the sample is not taken; the source holds it.

Reset
REQ-027 rst clears all stage valids: out_valid = 0, in_ready = 1 on the cycle after reset.
REQ-028 mean_cb, mean_cr, tag_out reset to 0; data registers in S1/S2 need no reset.
REQ-029 rst mid-stream discards every in-flight sample; no output for those samples after reset.

Configuration
REQ-030 Macro MEAN_CHROMA_CLAMP_EN defined: y is clamped to [Y_MIN, Y_MAX] in S1 before region/delta computation; latency unchanged.
REQ-031 MEAN_CHROMA_CLAMP_EN undefined: y is used raw; no clamp logic is present.

Structure
REQ-032 Package skintone_pkg holds K_L=125, K_H=188, Y_MIN=16, Y_MAX=235, CB_C=108, CR_C=154, CB_SL=47, CB_SH=109, CR_SL=47, CR_SH=240 (slopes at FRAC_W=9), and the region enum {LOW, MID, HIGH}.
REQ-033 Sub-module mean_chroma_lane (one channel: multiply + signed offset around centre, with stall enable) is instantiated twice, once for Cb and once for Cr; region/delta/stall logic stays in the top.

Verification (FRAC_W=9)
REQ-034 y=150, no stall -> 3 cycles later mean_cb=55296, mean_cr=78848, tag matches.
REQ-035 y=100 -> mean_cb=56471, mean_cr=77673; y=200 -> mean_cb=56604, mean_cr=81728; y=125 and y=188 -> centre values.
REQ-036 y=0: with clamp macro -> mean_cb=60419, mean_cr=73725; without -> 61171, 72973.
REQ-037 Back-to-back stream of 20 samples with out_ready toggled randomly -> outputs in order, none lost or duplicated; in_ready low exactly when out_valid && !out_ready.
REQ-038 Assert rst with 3 samples in flight -> out_valid = 0 next cycle; no stale output afterwards; the first new sample appears at latency 3.
